// File: rtl/mini_alu_core_if.sv
// ROM fetch port and video-RAM write port of the mini ALU core.
interface mini_alu_core_if #(
    parameter int unsigned IP_WIDTH = 8
);
    logic [IP_WIDTH-1:0] oIP;
    logic [27:0]         iInstruction;
    logic                oVGAWriteEnable;
    logic [15:0]         oVGAAddress;
    logic [2:0]          oVGAColor;

    modport master (
        output oIP,
        output oVGAWriteEnable,
        output oVGAAddress,
        output oVGAColor,
        input  iInstruction
    );

    modport slave (
        input  oIP,
        input  oVGAWriteEnable,
        input  oVGAAddress,
        input  oVGAColor,
        output iInstruction
    );
endinterface

// File: rtl/mini_alu_core.sv
// Two-stage (fetch/execute) microcontroller core with register file,
// return-address stack, video-RAM write strobe, LED latch and button input.
module mini_alu_core #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned NUM_REGS    = 8,
    parameter int unsigned IP_WIDTH    = 8,
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic                   Clock,
    input  logic                   Reset,
    mini_alu_core_if.master        bus,
    input  logic [4:0]             iButtons,
    output logic [7:0]             oLed,
    output logic                   oHalted,
    output logic                   oStackError
);
    localparam int unsigned INSTR_W = 28;
    localparam int unsigned RIDX_W  = $clog2(NUM_REGS);
    localparam int unsigned SP_W    = $clog2(STACK_DEPTH) + 1;
    localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0, OP_STO = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3,
        OP_INC  = 4'h4, OP_BLE = 4'h5, OP_BGE = 4'h6, OP_JMP = 4'h7,
        OP_CALL = 4'h8, OP_RET = 4'h9, OP_VGA = 4'hA, OP_BTN = 4'hB,
        OP_LED  = 4'hC, OP_AND = 4'hD, OP_OR  = 4'hE, OP_HALT = 4'hF
    } op_e;

    logic [IP_WIDTH-1:0]   pc_q, pc_d;
    logic [INSTR_W-1:0]    ir_q, ir_d;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic [IP_WIDTH-1:0]   stack_q [STACK_DEPTH];
    logic [IP_WIDTH-1:0]   stack_d [STACK_DEPTH];
    logic [SP_W-1:0]       sp_q, sp_d;
    logic                  halted_q, halted_d;
    logic                  stack_err_q, stack_err_d;
    logic [7:0]            led_q, led_d;
    logic                  vga_we_q, vga_we_d;
    logic [15:0]           vga_addr_q, vga_addr_d;
    logic [2:0]            vga_color_q, vga_color_d;

    op_e                   op;
    logic [RIDX_W-1:0]     dst_idx, s1_idx, s0_idx;
    logic [DATA_WIDTH-1:0] src1, src0, imm;
    logic [SP_W-1:0]       sp_dec;
    logic                  stack_full;
    logic                  taken;
    logic [IP_WIDTH-1:0]   target;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;

    // Instruction decode and combinational register reads
    assign op         = op_e'(ir_q[27:24]);
    assign dst_idx    = ir_q[16 +: RIDX_W];
    assign s1_idx     = ir_q[8 +: RIDX_W];
    assign s0_idx     = ir_q[0 +: RIDX_W];
    assign imm        = DATA_WIDTH'(ir_q[15:0]);
    assign src1       = regs_q[s1_idx];
    assign src0       = regs_q[s0_idx];
    assign sp_dec     = sp_q - SP_W'(1);
    assign stack_full = (sp_q == SP_W'(STACK_DEPTH));

    // Fetch, execute and next-state computation
    always_comb begin
        pc_d        = pc_q;
        ir_d        = ir_q;
        regs_d      = regs_q;
        stack_d     = stack_q;
        sp_d        = sp_q;
        halted_d    = halted_q;
        stack_err_d = stack_err_q;
        led_d       = led_q;
        vga_we_d    = 1'b0;
        vga_addr_d  = vga_addr_q;
        vga_color_d = vga_color_q;
        taken       = 1'b0;
        target      = IP_WIDTH'(ir_q[23:16]);
        wr_en       = 1'b0;
        wr_data     = '0;

        if (!halted_q) begin
            pc_d = pc_q + IP_WIDTH'(1);
            ir_d = bus.iInstruction;
            case (op)
                OP_NOP: ;
                OP_STO: begin wr_en = 1'b1; wr_data = imm; end
                OP_ADD: begin wr_en = 1'b1; wr_data = src1 + src0; end
                OP_SUB: begin wr_en = 1'b1; wr_data = src1 - src0; end
                OP_INC: begin wr_en = 1'b1; wr_data = src1 + DATA_WIDTH'(1); end
                OP_BLE: taken = (src1 <= src0);
                OP_BGE: taken = (src1 >= src0);
                OP_JMP: taken = 1'b1;
                OP_CALL: begin
                    // pc_q already points past the CALL: that is the return address
                    if (stack_full) begin
                        stack_err_d = 1'b1;
                    end else begin
                        stack_d[sp_q[SP_W-2:0]] = pc_q;
                        sp_d  = sp_q + SP_W'(1);
                        taken = 1'b1;
                    end
                end
                OP_RET: begin
                    if (sp_q == '0) begin
                        stack_err_d = 1'b1;
                    end else begin
                        target = stack_q[sp_dec[SP_W-2:0]];
                        sp_d   = sp_dec;
                        taken  = 1'b1;
                    end
                end
                OP_VGA: begin
                    vga_we_d    = 1'b1;
                    vga_addr_d  = {src1[7:0], src0[7:0]};
                    vga_color_d = ir_q[18:16];
                end
                OP_BTN: begin wr_en = 1'b1; wr_data = src1 + DATA_WIDTH'(iButtons); end
                OP_LED: led_d = src1[7:0];
                OP_AND: begin wr_en = 1'b1; wr_data = src1 & src0; end
                OP_OR:  begin wr_en = 1'b1; wr_data = src1 | src0; end
                OP_HALT: begin
                    halted_d = 1'b1;
                    pc_d     = pc_q;
                    ir_d     = ir_q;
                end
                default: ;
            endcase
            // Taken control transfer squashes the instruction fetched this cycle
            if (taken) begin
                pc_d = target;
                ir_d = NOP_INSTR;
            end
            if (wr_en) begin
                regs_d[dst_idx] = wr_data;
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge Clock) begin
        if (Reset) begin
            pc_q        <= '0;
            ir_q        <= NOP_INSTR;
            regs_q      <= '{default: '0};
            stack_q     <= '{default: '0};
            sp_q        <= '0;
            halted_q    <= 1'b0;
            stack_err_q <= 1'b0;
            led_q       <= '0;
            vga_we_q    <= 1'b0;
            vga_addr_q  <= '0;
            vga_color_q <= '0;
        end else begin
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            regs_q      <= regs_d;
            stack_q     <= stack_d;
            sp_q        <= sp_d;
            halted_q    <= halted_d;
            stack_err_q <= stack_err_d;
            led_q       <= led_d;
            vga_we_q    <= vga_we_d;
            vga_addr_q  <= vga_addr_d;
            vga_color_q <= vga_color_d;
        end
    end

    assign bus.oIP             = pc_q;
    assign bus.oVGAWriteEnable = vga_we_q;
    assign bus.oVGAAddress     = vga_addr_q;
    assign bus.oVGAColor       = vga_color_q;
    assign oLed                = led_q;
    assign oHalted             = halted_q;
    assign oStackError         = stack_err_q;
endmodule

// File: tb/tb_mini_alu_core.sv
// Self-checking bench for mini_alu_core: directed scenarios plus random
// programs compared against an instruction-level model.
module tb_mini_alu_core;
    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic [4:0] iButtons = '0;
    logic [7:0] oLed;
    logic       oHalted;
    logic       oStackError;

    int vectors = 0;
    int miscompares = 0;

    logic [27:0] rom [256];
    int          a_trace[$];
    logic [18:0] a_vga[$];
    int          a_vga_ip[$];

    logic [15:0] m_regs [8];
    logic [7:0]  m_led;
    logic        m_err;
    int          m_trace[$];
    logic [18:0] m_vga[$];

    mini_alu_core_if #(.IP_WIDTH(8)) bus ();

    mini_alu_core #(
        .DATA_WIDTH(16), .NUM_REGS(8), .IP_WIDTH(8), .STACK_DEPTH(4)
    ) dut (
        .Clock(Clock), .Reset(Reset), .bus(bus), .iButtons(iButtons),
        .oLed(oLed), .oHalted(oHalted), .oStackError(oStackError)
    );

    always #5 Clock = ~Clock;

    assign bus.iInstruction = rom[bus.oIP];

    // Records every video-RAM write strobe together with the fetch address
    always @(negedge Clock) begin
        if (!Reset && bus.oVGAWriteEnable) begin
            a_vga.push_back({bus.oVGAAddress, bus.oVGAColor});
            a_vga_ip.push_back(int'(bus.oIP));
        end
    end

    function automatic logic [27:0] ins(input int op, input int d, input int s1, input int s0);
        return {4'(op), 8'(d), 8'(s1), 8'(s0)};
    endfunction

    function automatic int first_diff(input int a[$], input int b[$]);
        int n = (a.size() < b.size()) ? a.size() : b.size();
        for (int i = 0; i < n; i++) if (a[i] != b[i]) return i;
        if (a.size() != b.size()) return n;
        return -1;
    endfunction

    function automatic int elem(input int q[$], input int i);
        if (i >= 0 && i < q.size()) return q[i];
        return -1;
    endfunction

    task automatic rom_clear();
        for (int i = 0; i < 256; i++) rom[i] = ins(15, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge Clock);
        Reset = 1'b1;
        repeat (2) @(negedge Clock);
        a_vga = {};
        a_vga_ip = {};
        Reset = 1'b0;
    endtask

    // Captures oIP each cycle from reset release until the core halts
    task automatic dut_run(input int budget, output bit timeout);
        a_trace = {};
        timeout = 1'b1;
        for (int c = 0; c < budget; c++) begin
            if (oHalted) begin
                timeout = 1'b0;
                break;
            end
            a_trace.push_back(int'(bus.oIP));
            @(negedge Clock);
        end
    endtask

    // Instruction-level model: executes the ROM program architecturally.
    // A fetch-ahead core shows oIP = addr+1 while executing addr, and one
    // extra cycle at the target after any taken transfer.
    task automatic model_run(input logic [4:0] btn);
        int pc = 0;
        int stk[$];
        logic [27:0] w;
        int op, d;
        logic [15:0] a, b;
        bit taken;
        int tgt;
        m_trace = {};
        m_vga = {};
        m_led = '0;
        m_err = 1'b0;
        for (int r = 0; r < 8; r++) m_regs[r] = '0;
        m_trace.push_back(0);
        for (int step = 0; step < 1000; step++) begin
            w = rom[pc];
            op = int'(w[27:24]);
            d = int'(w[23:16]);
            a = m_regs[int'(w[15:8]) % 8];
            b = m_regs[int'(w[7:0]) % 8];
            taken = 1'b0;
            tgt = d;
            m_trace.push_back((pc + 1) % 256);
            if (op == 15) break;
            case (op)
                1:  m_regs[d % 8] = w[15:0];
                2:  m_regs[d % 8] = a + b;
                3:  m_regs[d % 8] = a - b;
                4:  m_regs[d % 8] = a + 16'd1;
                5:  taken = (a <= b);
                6:  taken = (a >= b);
                7:  taken = 1'b1;
                8:  if (stk.size() < 4) begin stk.push_back((pc + 1) % 256); taken = 1'b1; end
                    else m_err = 1'b1;
                9:  if (stk.size() > 0) begin tgt = stk.pop_back(); taken = 1'b1; end
                    else m_err = 1'b1;
                10: m_vga.push_back({a[7:0], b[7:0], w[18:16]});
                11: m_regs[d % 8] = a + 16'(btn);
                12: m_led = a[7:0];
                13: m_regs[d % 8] = a & b;
                14: m_regs[d % 8] = a | b;
                default: ;
            endcase
            if (taken) begin
                m_trace.push_back(tgt);
                pc = tgt;
            end else begin
                pc = (pc + 1) % 256;
            end
        end
    endtask

    task automatic test_reset();
        rom_clear();
        iButtons = '0;
        do_reset();
        vectors++;
        if (bus.oIP !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_oIP got %h want 00", bus.oIP);
        end
        vectors++;
        if ({bus.oVGAWriteEnable, bus.oVGAAddress, bus.oVGAColor, oLed, oHalted, oStackError} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs got we=%b addr=%h col=%h led=%h halt=%b err=%b want all 0",
                     bus.oVGAWriteEnable, bus.oVGAAddress, bus.oVGAColor, oLed, oHalted, oStackError);
        end
        for (int r = 0; r < 8; r++) begin
            vectors++;
            if (dut.regs_q[r] !== 16'h0) begin
                miscompares++;
                $display("FAIL reset_R%0d got %h want 0000", r, dut.regs_q[r]);
            end
        end
    endtask

    task automatic test_alu_seq();
        int want[$] = '{0, 1, 2, 3, 4, 5};
        bit to;
        int k;
        rom_clear();
        rom[0] = ins(1, 1, 0, 5);
        rom[1] = ins(1, 2, 0, 3);
        rom[2] = ins(2, 3, 1, 2);
        rom[3] = ins(3, 4, 1, 2);
        do_reset();
        dut_run(50, to);
        vectors++;
        if (to) begin miscompares++; $display("FAIL alu_timeout got no halt want halt"); end
        k = first_diff(a_trace, want);
        vectors++;
        if (k >= 0) begin
            miscompares++;
            $display("FAIL alu_trace idx %0d got %0h want %0h", k, elem(a_trace, k), elem(want, k));
        end
        vectors++;
        if (dut.regs_q[3] !== 16'd8) begin miscompares++; $display("FAIL alu_add got %h want 0008", dut.regs_q[3]); end
        vectors++;
        if (dut.regs_q[4] !== 16'd2) begin miscompares++; $display("FAIL alu_sub got %h want 0002", dut.regs_q[4]); end
    endtask

    task automatic test_branch();
        int want[$] = '{0, 1, 2, 3, 4, 5, 'h10, 'h11, 'h12, 'h20, 'h21};
        bit to;
        int k;
        rom_clear();
        rom[0]    = ins(1, 1, 0, 5);
        rom[1]    = ins(1, 2, 0, 3);
        rom[2]    = ins(5, 'h10, 1, 2);
        rom[3]    = ins(1, 5, 0, 'h77);
        rom[4]    = ins(5, 'h10, 2, 1);
        rom[5]    = ins(1, 6, 0, 'h99);
        rom['h10] = ins(6, 'h20, 2, 1);
        rom['h11] = ins(6, 'h20, 1, 1);
        rom['h12] = ins(1, 7, 0, 1);
        do_reset();
        dut_run(60, to);
        vectors++;
        if (to) begin miscompares++; $display("FAIL branch_timeout got no halt want halt"); end
        k = first_diff(a_trace, want);
        vectors++;
        if (k >= 0) begin
            miscompares++;
            $display("FAIL branch_trace idx %0d got %0h want %0h", k, elem(a_trace, k), elem(want, k));
        end
        vectors++;
        if (dut.regs_q[5] !== 16'h0077) begin miscompares++; $display("FAIL branch_fallthru got %h want 0077", dut.regs_q[5]); end
        vectors++;
        if (dut.regs_q[6] !== 16'h0) begin miscompares++; $display("FAIL ble_squash got %h want 0000", dut.regs_q[6]); end
        vectors++;
        if (dut.regs_q[7] !== 16'h0) begin miscompares++; $display("FAIL bge_squash got %h want 0000", dut.regs_q[7]); end
    endtask

    task automatic test_call_nested();
        int want[$] = '{0, 1, 2, 3, 'h20, 'h21, 'h30, 'h31, 'h40, 'h41, 'h31, 'h32, 'h21, 'h22, 3, 4};
        bit to;
        int k;
        rom_clear();
        rom[0] = ins(0, 0, 0, 0);
        rom[1] = ins(0, 0, 0, 0);
        rom[2] = ins(8, 'h20, 0, 0);
        rom['h20] = ins(8, 'h30, 0, 0);
        rom['h30] = ins(8, 'h40, 0, 0);
        rom['h40] = ins(9, 0, 0, 0);
        rom['h31] = ins(9, 0, 0, 0);
        rom['h21] = ins(9, 0, 0, 0);
        do_reset();
        dut_run(60, to);
        vectors++;
        if (to) begin miscompares++; $display("FAIL call_timeout got no halt want halt"); end
        k = first_diff(a_trace, want);
        vectors++;
        if (k >= 0) begin
            miscompares++;
            $display("FAIL call_trace idx %0d got %0h want %0h", k, elem(a_trace, k), elem(want, k));
        end
        vectors++;
        if (oStackError !== 1'b0) begin miscompares++; $display("FAIL call_err got %b want 0", oStackError); end
    endtask

    task automatic test_stack_errors();
        int want[$] = '{0, 1, 'h10, 'h11, 'h20, 'h21, 'h30, 'h31, 'h40, 'h41, 'h42, 'h43};
        int want_ret[$] = '{0, 1, 2, 3};
        bit to;
        int k;
        rom_clear();
        rom[0]    = ins(8, 'h10, 0, 0);
        rom['h10] = ins(8, 'h20, 0, 0);
        rom['h20] = ins(8, 'h30, 0, 0);
        rom['h30] = ins(8, 'h40, 0, 0);
        rom['h40] = ins(8, 'h50, 0, 0);
        rom['h41] = ins(1, 1, 0, 'hAB);
        rom['h50] = ins(1, 2, 0, 1);
        do_reset();
        dut_run(60, to);
        vectors++;
        if (to) begin miscompares++; $display("FAIL ovf_timeout got no halt want halt"); end
        k = first_diff(a_trace, want);
        vectors++;
        if (k >= 0) begin
            miscompares++;
            $display("FAIL ovf_trace idx %0d got %0h want %0h", k, elem(a_trace, k), elem(want, k));
        end
        vectors++;
        if (oStackError !== 1'b1) begin miscompares++; $display("FAIL ovf_err got %b want 1", oStackError); end
        vectors++;
        if (dut.regs_q[1] !== 16'h00AB || dut.regs_q[2] !== 16'h0) begin
            miscompares++;
            $display("FAIL ovf_regs got R1=%h R2=%h want R1=00ab R2=0000", dut.regs_q[1], dut.regs_q[2]);
        end
        rom_clear();
        rom[0] = ins(9, 'h30, 0, 0);
        rom[1] = ins(1, 1, 0, 7);
        do_reset();
        vectors++;
        if (oStackError !== 1'b0) begin miscompares++; $display("FAIL err_clear got %b want 0", oStackError); end
        dut_run(40, to);
        vectors++;
        if (to) begin miscompares++; $display("FAIL udf_timeout got no halt want halt"); end
        k = first_diff(a_trace, want_ret);
        vectors++;
        if (k >= 0) begin
            miscompares++;
            $display("FAIL udf_trace idx %0d got %0h want %0h", k, elem(a_trace, k), elem(want_ret, k));
        end
        vectors++;
        if (oStackError !== 1'b1 || dut.regs_q[1] !== 16'd7) begin
            miscompares++;
            $display("FAIL udf_err got err=%b R1=%h want err=1 R1=0007", oStackError, dut.regs_q[1]);
        end
    endtask

    task automatic test_io();
        bit to;
        rom_clear();
        rom[0] = ins(1, 1, 0, 'h12);
        rom[1] = ins(1, 2, 0, 'h34);
        rom[2] = ins(10, 5, 1, 2);
        rom[3] = ins(1, 0, 0, 1);
        rom[4] = ins(11, 5, 0, 0);
        rom[5] = ins(1, 3, 'h01, 'hA5);
        rom[6] = ins(12, 0, 3, 0);
        iButtons = 5'b00100;
        do_reset();
        dut_run(40, to);
        vectors++;
        if (to) begin miscompares++; $display("FAIL io_timeout got no halt want halt"); end
        vectors++;
        if (a_vga.size() != 1) begin
            miscompares++;
            $display("FAIL vga_count got %0d want 1", a_vga.size());
        end else if (a_vga[0] !== {16'h1234, 3'b101} || a_vga_ip[0] != 4) begin
            miscompares++;
            $display("FAIL vga_write got addr=%h col=%b at ip %0d want addr=1234 col=101 at ip 4",
                     a_vga[0][18:3], a_vga[0][2:0], a_vga_ip[0]);
        end
        vectors++;
        if (bus.oVGAWriteEnable !== 1'b0 || bus.oVGAAddress !== 16'h1234 || bus.oVGAColor !== 3'b101) begin
            miscompares++;
            $display("FAIL vga_hold got we=%b addr=%h col=%b want we=0 addr=1234 col=101",
                     bus.oVGAWriteEnable, bus.oVGAAddress, bus.oVGAColor);
        end
        vectors++;
        if (dut.regs_q[5] !== 16'd5) begin miscompares++; $display("FAIL btn got %h want 0005", dut.regs_q[5]); end
        vectors++;
        if (oLed !== 8'hA5) begin miscompares++; $display("FAIL led got %h want a5", oLed); end
    endtask

    task automatic test_halt_reset();
        bit to;
        bit moved;
        rom_clear();
        rom[0] = ins(1, 1, 'hFF, 'hFF);
        rom[1] = ins(4, 1, 1, 0);
        rom[2] = ins(1, 3, 'h01, 'hA5);
        rom[3] = ins(12, 0, 3, 0);
        rom[4] = ins(15, 0, 0, 0);
        rom[5] = ins(1, 4, 0, 'h55);
        iButtons = '0;
        do_reset();
        dut_run(40, to);
        vectors++;
        if (to) begin miscompares++; $display("FAIL halt_timeout got no halt want halt"); end
        vectors++;
        if (dut.regs_q[1] !== 16'h0) begin miscompares++; $display("FAIL inc_wrap got %h want 0000", dut.regs_q[1]); end
        moved = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (bus.oIP !== 8'h05 || oHalted !== 1'b1 || bus.oVGAWriteEnable !== 1'b0) moved = 1'b1;
            @(negedge Clock);
        end
        vectors++;
        if (moved) begin
            miscompares++;
            $display("FAIL halt_frozen got ip=%h halt=%b want ip=05 halt=1 for 100 cycles", bus.oIP, oHalted);
        end
        vectors++;
        if (dut.regs_q[4] !== 16'h0 || oLed !== 8'hA5) begin
            miscompares++;
            $display("FAIL halt_hold got R4=%h led=%h want R4=0000 led=a5", dut.regs_q[4], oLed);
        end
        Reset = 1'b1;
        @(negedge Clock);
        vectors++;
        if (bus.oIP !== 8'h00 || oHalted !== 1'b0 || oLed !== 8'h00 || oStackError !== 1'b0) begin
            miscompares++;
            $display("FAIL halt_reset got ip=%h halt=%b led=%h err=%b want 00 0 00 0", bus.oIP, oHalted, oLed, oStackError);
        end
        for (int r = 0; r < 8; r++) begin
            vectors++;
            if (dut.regs_q[r] !== 16'h0) begin
                miscompares++;
                $display("FAIL halt_reset_R%0d got %h want 0000", r, dut.regs_q[r]);
            end
        end
        Reset = 1'b0;
    endtask

    task automatic test_random();
        int ops[14] = '{0, 1, 2, 3, 4, 5, 6, 7, 9, 10, 11, 12, 13, 14};
        bit to;
        int k, op, d;
        for (int p = 0; p < 25; p++) begin
            rom_clear();
            for (int a = 0; a < 48; a++) begin
                op = ops[$urandom_range(0, 13)];
                if (op >= 5 && op <= 7) begin
                    d = a + 1 + int'($urandom_range(1, 8));
                    if (d > 48) d = 48;
                end else begin
                    d = int'($urandom_range(0, 255));
                end
                rom[a] = ins(op, d, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
            end
            iButtons = 5'($urandom);
            model_run(iButtons);
            do_reset();
            dut_run(400, to);
            vectors++;
            if (to) begin miscompares++; $display("FAIL rnd%0d_timeout got no halt want halt", p); end
            k = first_diff(a_trace, m_trace);
            vectors++;
            if (k >= 0) begin
                miscompares++;
                $display("FAIL rnd%0d_trace idx %0d got %0h want %0h", p, k, elem(a_trace, k), elem(m_trace, k));
            end
            for (int r = 0; r < 8; r++) begin
                vectors++;
                if (dut.regs_q[r] !== m_regs[r]) begin
                    miscompares++;
                    $display("FAIL rnd%0d_R%0d got %h want %h", p, r, dut.regs_q[r], m_regs[r]);
                end
            end
            vectors++;
            if (oLed !== m_led || oStackError !== m_err) begin
                miscompares++;
                $display("FAIL rnd%0d_io got led=%h err=%b want led=%h err=%b", p, oLed, oStackError, m_led, m_err);
            end
            vectors++;
            if (a_vga.size() != m_vga.size()) begin
                miscompares++;
                $display("FAIL rnd%0d_vga_count got %0d want %0d", p, a_vga.size(), m_vga.size());
            end else begin
                foreach (m_vga[i]) begin
                    if (a_vga[i] !== m_vga[i]) begin
                        miscompares++;
                        $display("FAIL rnd%0d_vga%0d got %h want %h", p, i, a_vga[i], m_vga[i]);
                        break;
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu_seq();
        test_branch();
        test_call_nested();
        test_stack_errors();
        test_io();
        test_halt_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mini_alu_core.md
Name: mini_alu_core

Overview:
- Parametrised successor to the game-board mini CPU: a 2-stage (fetch / execute) microcontroller core.
- Fetches 28-bit instructions from an external combinational ROM. Executes ALU, branch and I/O ops over an internal register file.
- Replaces the single-entry return buffer with a multi-level call stack and adds SUB/AND/OR/HALT.
- Drives the video-RAM write port, LED latch and button sampling for the whack-a-mole top level.

Parameters:
- DATA_WIDTH, 16, register/ALU width (must be >= 8).
- NUM_REGS, 8, register file entries (power of 2, 2..256).
- IP_WIDTH, 8, instruction pointer width.
- STACK_DEPTH, 4, return-address stack entries (power of 2, >= 2).

Ports:
- Clock  in  1  system clock.
- Reset  in  1  synchronous, active-high.
- oIP  out  IP_WIDTH  fetch address to ROM (registered PC).
- iInstruction  in  28  ROM[oIP], combinational, valid same cycle.
- iButtons  in  5  debounced buttons {UP,DOWN,LEFT,RIGHT,CNTR}.
- oVGAWriteEnable  out  1  one-cycle video RAM write strobe.
- oVGAAddress  out  16  {column,row} write address.
- oVGAColor  out  3  RGB write data.
- oLed  out  8  LED latch.
- oHalted  out  1  core stopped by HALT.
- oStackError  out  1  sticky: call-stack overflow or underflow occurred.

Behaviour:
- Instruction fields: op[27:24], dst[23:16], s1[15:8], s0[7:0].
  - Register index = field low log2(NUM_REGS) bits.
  - imm = {s1,s0}, zero-extended or truncated to DATA_WIDTH.
- Reset (synchronous, highest priority, aborts any operation):
  - PC=0, IR=NOP, all registers=0, stack pointer=0.
  - All outputs 0.
- Fetch: every non-halted cycle IR<=iInstruction and PC<=PC+1, mod 2^IP_WIDTH.
- Execute: IR is executed in the following cycle, reading registers combinationally.
  - Register writes land at the end of that cycle.
  - No forwarding hazard exists: each instruction executes one cycle after the previous one.
- Taken branch/CALL/RET: PC<=target and IR<=NOP (squash the already-fetched instruction). Penalty is one cycle.
  - Target = dst zero-extended to IP_WIDTH.
- Opcodes (arithmetic mod 2^DATA_WIDTH, compares unsigned):
  - 0 NOP.
  - 1 STO: R[dst]=imm.
  - 2 ADD: R[dst]=R[s1]+R[s0].
  - 3 SUB: R[dst]=R[s1]-R[s0].
  - 4 INC: R[dst]=R[s1]+1.
  - 5 BLE: taken if R[s1]<=R[s0].
  - 6 BGE: taken if R[s1]>=R[s0].
  - 7 JMP: always taken.
  - 8 CALL: push PC (address of CALL +1), jump to dst.
  - 9 RET: pop into PC.
  - A VGA: write strobe (see below).
  - B BTN: R[dst]=R[s1]+zero-extended iButtons, sampled in the execute cycle.
  - C LED: oLed<=R[s1][7:0].
  - D AND.
  - E OR.
  - F HALT.
- VGA op: in the cycle after execute, for exactly one cycle:
  - oVGAWriteEnable=1.
  - oVGAAddress={R[s1][7:0],R[s0][7:0]}.
  - oVGAColor=dst[2:0].
  - oVGAAddress/oVGAColor hold their last values otherwise.
- Call stack:
  - CALL with STACK_DEPTH entries already used: no push, not taken, oStackError<=1, execution continues sequentially.
  - RET with empty stack: no pop, not taken (behaves as NOP), oStackError<=1.
  - oStackError clears only on Reset.
- HALT: PC and IR freeze; oHalted<=1 the cycle after execute.
  - Registers, oLed and stack hold; no further writes or strobes.
  - Only Reset exits.
- oLed holds its value between LED ops.
- Undefined behaviour: none. All 16 opcodes are defined.

Test Plan:
- Reset then ROM {STO R1,0x0005; STO R2,0x0003; ADD R3,R1,R2; SUB R4,R1,R2} -> R3=8, R4=2; oIP sequence 0,1,2,3,4 with no bubbles.
- BLE not taken vs taken: R1=5, R2=3, BLE 0x10,R1,R2 -> sequential; swap operands -> next oIP=0x10; the instruction after the BLE is not executed (its register is unchanged).
- Nested CALL depth 3 (0x02->0x20->0x30->0x40), then RET×3 -> returns to 0x31, 0x21, 0x03 in order; oStackError=0.
- STACK_DEPTH=4: issue 5 nested CALLs -> 5th falls through, oStackError=1. RET on empty stack after Reset -> NOP, oStackError=1.
- VGA with R1=0x0012, R2=0x0034, dst=0b101 -> one-cycle oVGAWriteEnable, oVGAAddress=0x1234, oVGAColor=3'b101. BTN with iButtons=5'b00100, R0=1 -> R[dst]=5. LED of R3=0x1A5 -> oLed=0xA5.
- INC of R=0xFFFF wraps to 0. HALT -> oHalted=1, oIP frozen for 100 cycles. Reset mid-HALT -> oIP=0, oHalted=0, oLed=0, all registers 0.
